// File: rtl/msb_index_decoder.sv
// Bit-index to mask decoder (one-hot, thermometer, descending one-hot burst) with valid/ready on both sides.
// Optional macro MSB_DEC_ERR_EN adds the err port and makes mode 3 a flagged no-op.
module msb_index_decoder #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_idx,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_mask,
  output logic          out_last,
  output logic          busy
`ifdef MSB_DEC_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] cnt_dec;
  logic          valid_p1, valid_nxt;
  logic [W-1:0]  mask_p1, mask_nxt;
  logic          last_p1, last_nxt;
`ifdef MSB_DEC_ERR_EN
  logic          err_p1, err_nxt;
`endif

  function automatic logic [W-1:0] onehot(input logic [IW-1:0] idx);
    logic [W-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Bits [idx:0] set; avoids the (2<<idx)-1 overflow at idx=W-1.
  function automatic logic [W-1:0] thermo(input logic [IW-1:0] idx);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = (IW'(i) <= idx);
    return m;
  endfunction

  assign cnt_dec = cnt - IW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = valid_p1;
    mask_nxt  = mask_p1;
    last_nxt  = last_p1;
`ifdef MSB_DEC_ERR_EN
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (in_mode)
            2'd1: begin
              state_nxt = HOLD;
              valid_nxt = 1'b1;
              mask_nxt  = thermo(in_idx);
              last_nxt  = 1'b1;
            end
            2'd2: begin
              state_nxt = BURST;
              cnt_nxt   = in_idx;
              valid_nxt = 1'b1;
              mask_nxt  = onehot(in_idx);
              last_nxt  = (in_idx == '0);
            end
`ifdef MSB_DEC_ERR_EN
            2'd3: begin
              err_nxt = 1'b1;
            end
`endif
            default: begin
              state_nxt = HOLD;
              valid_nxt = 1'b1;
              mask_nxt  = onehot(in_idx);
              last_nxt  = 1'b1;
            end
          endcase
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          mask_nxt  = '0;
          last_nxt  = 1'b0;
        end
      end
      BURST: begin
        if (out_ready) begin
          if (cnt == '0) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            mask_nxt  = '0;
            last_nxt  = 1'b0;
          end else begin
            cnt_nxt  = cnt_dec;
            mask_nxt = onehot(cnt_dec);
            last_nxt = (cnt_dec == '0);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        mask_nxt  = '0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  // Output register stage (p1)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      valid_p1 <= 1'b0;
      mask_p1  <= '0;
      last_p1  <= 1'b0;
`ifdef MSB_DEC_ERR_EN
      err_p1   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      valid_p1 <= valid_nxt;
      mask_p1  <= mask_nxt;
      last_p1  <= last_nxt;
`ifdef MSB_DEC_ERR_EN
      err_p1   <= err_nxt;
`endif
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = valid_p1;
  assign out_mask  = mask_p1;
  assign out_last  = last_p1;
`ifdef MSB_DEC_ERR_EN
  assign err       = err_p1;
`endif

endmodule
